// File: rtl/al_pkg.sv
// Shared definitions for the parameter auto-load path: reader FSM states and
// the constants the sequencer and PROM reader agree on.
package al_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_STORE,
    ST_DESEL
  } state_e;

  localparam logic [5:0]  MAX_ADDR     = 6'd33;
  localparam logic [7:0]  DEF_CMD_READ = 8'h03;
  localparam logic [15:0] BLANK_WORD   = 16'hFFFF;

  // Word address to PROM byte address; wraps modulo 2^24.
  function automatic logic [23:0] word_to_byte_addr(input logic [23:0] base,
                                                    input logic [5:0]  waddr);
    return base + {17'd0, waddr, 1'b0};
  endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// SCK phase generator: alternating one-cycle RISE/FALL enables, one every N
// CLK cycles while EN is high; restarts from zero whenever EN drops.
module spi_tick_gen (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic [3:0] N,
  output logic       RISE,
  output logic       FALL
);

  logic [3:0] cnt_q;
  logic       phase_q;
  logic       tick;

  assign tick = EN && (cnt_q == N - 4'd1);
  assign RISE = tick && !phase_q;
  assign FALL = tick &&  phase_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (!EN) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (tick) begin
      cnt_q   <= '0;
      phase_q <= ~phase_q;
    end else begin
      cnt_q   <= cnt_q + 4'd1;
    end
  end

endmodule

// File: rtl/al_prom_reader.sv
// Auto-load responder: on EXECUTE, reads one 16-bit word from the SPI
// (mode 0) parameter PROM and strobes it into the parameter bank.
module al_prom_reader
  import al_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 4,
  parameter logic [7:0]  CMD_READ  = DEF_CMD_READ,
  parameter logic [23:0] BASE_ADDR = 24'h000000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EXECUTE,
  input  logic [5:0]  ADDR,
  output logic        BUSY,
  output logic        WE,
  output logic        BLANK,
  output logic [5:0]  WADDR,
  output logic [15:0] DATA_OUT,
  output logic        CS_N,
  output logic        SCK,
  output logic        MOSI,
  input  logic        MISO
);

  localparam logic [5:0] LAST_BIT   = 6'd47;
  localparam logic [5:0] DESEL_LAST = 6'(2 * CLK_DIV - 2);

  state_e      state_q, state_d;
  logic        busy_q, busy_d;
  logic        we_q, we_d;
  logic        blank_q, blank_d;
  logic [5:0]  waddr_q, waddr_d;
  logic [15:0] data_q, data_d;
  logic        cs_n_q, cs_n_d;
  logic        sck_q, sck_d;
  logic        mosi_q, mosi_d;
  logic [31:0] tx_q, tx_d;
  logic [15:0] rx_q, rx_d;
  logic [5:0]  bit_q, bit_d;
  logic        rise, fall;

  spi_tick_gen u_tick (
    .CLK  (CLK),
    .RST  (RST),
    .EN   (state_q == ST_SHIFT),
    .N    (4'(CLK_DIV)),
    .RISE (rise),
    .FALL (fall)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      we_q    <= 1'b0;
      blank_q <= 1'b0;
      waddr_q <= '0;
      data_q  <= '0;
      cs_n_q  <= 1'b1;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      we_q    <= we_d;
      blank_q <= blank_d;
      waddr_q <= waddr_d;
      data_q  <= data_d;
      cs_n_q  <= cs_n_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      bit_q   <= bit_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    we_d    = 1'b0;
    blank_d = 1'b0;
    waddr_d = waddr_q;
    data_d  = data_q;
    cs_n_d  = cs_n_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    bit_d   = bit_q;
    unique case (state_q)
      ST_IDLE: begin
        if (EXECUTE && !busy_q) begin
          state_d = ST_SHIFT;
          busy_d  = 1'b1;
          cs_n_d  = 1'b0;
          waddr_d = ADDR;
          tx_d    = {CMD_READ, word_to_byte_addr(BASE_ADDR, ADDR)};
          mosi_d  = CMD_READ[7];
          bit_d   = '0;
        end
      end
      ST_SHIFT: begin
        if (rise) begin
          sck_d = 1'b1;
          rx_d  = {rx_q[14:0], MISO};
        end
        // The falling edge of the last bit is also the Store edge, so the
        // strobe and deselect are registered here rather than in ST_STORE.
        if (fall) begin
          sck_d = 1'b0;
          if (bit_q == LAST_BIT) begin
            state_d = ST_STORE;
            cs_n_d  = 1'b1;
            mosi_d  = 1'b0;
            data_d  = rx_q;
            we_d    = (rx_q != BLANK_WORD);
            blank_d = (rx_q == BLANK_WORD);
            bit_d   = '0;
          end else begin
            bit_d   = bit_q + 6'd1;
            tx_d    = {tx_q[30:0], 1'b0};
            mosi_d  = tx_q[30];
          end
        end
      end
      ST_STORE: begin
        state_d = ST_DESEL;
      end
      ST_DESEL: begin
        if (bit_q == DESEL_LAST) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          bit_d   = bit_q + 6'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign BUSY     = busy_q;
  assign WE       = we_q;
  assign BLANK    = blank_q;
  assign WADDR    = waddr_q;
  assign DATA_OUT = data_q;
  assign CS_N     = cs_n_q;
  assign SCK      = sck_q;
  assign MOSI     = mosi_q;

endmodule

// File: tb/tb_al_prom_reader.sv
// Directed bench for al_prom_reader: PROM model on the SPI pins, scoreboard
// of expected parameter-bank strobes checked when WE/BLANK fire.
module tb_al_prom_reader;

  localparam int N       = 4;
  localparam int T_STORE = 96 * N;
  localparam int T_BUSY  = 98 * N;
  localparam logic [27:0] RSTV = {3'b000, 6'd0, 16'd0, 3'b100};

  logic        CLK = 1'b0, RST = 1'b1, EXECUTE = 1'b0, MISO = 1'b0;
  logic [5:0]  ADDR = '0;
  logic        BUSY, WE, BLANK, CS_N, SCK, MOSI;
  logic [5:0]  WADDR;
  logic [15:0] DATA_OUT;

  logic        w_exe = 1'b0, w_miso = 1'b0;
  logic [5:0]  w_addr = 6'd1;
  logic        w_busy, w_we, w_blank, w_cs_n, w_sck, w_mosi;
  logic [5:0]  w_waddr;
  logic [15:0] w_data;

  always #5 CLK = ~CLK;

  al_prom_reader #(.CLK_DIV(N), .CMD_READ(8'h03), .BASE_ADDR(24'h000000)) u_dut (
    .CLK(CLK), .RST(RST), .EXECUTE(EXECUTE), .ADDR(ADDR), .BUSY(BUSY), .WE(WE),
    .BLANK(BLANK), .WADDR(WADDR), .DATA_OUT(DATA_OUT), .CS_N(CS_N), .SCK(SCK),
    .MOSI(MOSI), .MISO(MISO));

  al_prom_reader #(.CLK_DIV(N), .CMD_READ(8'h03), .BASE_ADDR(24'hFFFFFE)) u_wrap (
    .CLK(CLK), .RST(RST), .EXECUTE(w_exe), .ADDR(w_addr), .BUSY(w_busy), .WE(w_we),
    .BLANK(w_blank), .WADDR(w_waddr), .DATA_OUT(w_data), .CS_N(w_cs_n), .SCK(w_sck),
    .MOSI(w_mosi), .MISO(w_miso));

  typedef struct {
    logic [5:0]  waddr;
    logic [15:0] data;
    logic        blank;
    int          t;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0, n_err = 0, cyc = 0, we_cnt = 0;
  int   hi_run = 0, min_gap = 1000;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // PROM model: captures opcode+address, then serves a word on MISO.
  logic [31:0] pcap = '0, wcap = '0;
  logic [15:0] prom_word = '0, pword = '0;
  logic        prom_integ = 1'b0;
  int          pbit = 0, wbit = 0;

  always @(negedge CS_N) pbit = 0;
  always @(posedge SCK) if (!CS_N) begin
    if (pbit < 32) pcap = {pcap[30:0], MOSI};
    pbit++;
    if (pbit == 32)
      pword = prom_integ ? ({10'd0, pcap[6:1]} ^ 16'h5A00) : prom_word;
  end
  always @(negedge SCK) if (!CS_N && pbit >= 32 && pbit < 48) MISO = pword[47 - pbit];

  always @(negedge w_cs_n) wbit = 0;
  always @(posedge w_sck) if (!w_cs_n) begin
    if (wbit < 32) wcap = {wcap[30:0], w_mosi};
    wbit++;
  end

  always @(negedge CLK) begin : mon
    exp_t e;
    if (CS_N) hi_run++;
    else begin
      if (hi_run > 0 && hi_run < min_gap) min_gap = hi_run;
      hi_run = 0;
    end
    if (WE || BLANK) begin
      we_cnt += int'(WE);
      chk("strobe_pending", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("strobe_kind", {BLANK, WE}, {e.blank, !e.blank});
        chk("strobe_waddr", WADDR, e.waddr);
        chk("strobe_data", DATA_OUT, e.data);
        chk("strobe_time", cyc, e.t);
      end
    end
  end

  function automatic logic [27:0] outs();
    return {BUSY, WE, BLANK, WADDR, DATA_OUT, CS_N, SCK, MOSI};
  endfunction

  task automatic accept(input logic [5:0] a);
    @(negedge CLK);
    ADDR    = a;
    EXECUTE = 1'b1;
    @(posedge CLK);
    #1;
    EXECUTE = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (BUSY !== 1'b0 && n < 2000) begin
      @(posedge CLK);
      #1;
      n++;
    end
    chk({tag, "_idle_bound"}, n < 2000, 1);
  endtask

  task automatic run_to(input int t);
    while (cyc < t) begin
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    int t0, n, base;

    // reset state, then asynchronous reset in idle and mid-shift
    repeat (3) @(posedge CLK);
    #1 chk("reset_vals", outs(), RSTV);
    @(negedge CLK) RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b1;
    #1 chk("reset_idle", outs(), RSTV);
    @(negedge CLK) RST = 1'b0;

    prom_word = 16'h1234;
    accept(6'd3);
    t0 = cyc;
    run_to(t0 + 100);
    chk("shift_active", {BUSY, CS_N}, 2'b10);
    RST = 1'b1;
    #1 chk("reset_shift", outs(), RSTV);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (5) @(negedge CLK);
    chk("reset_no_we", we_cnt, 0);

    // single read
    prom_word = 16'hA5C3;
    accept(6'd5);
    t0 = cyc;
    chk("accept_pins", {BUSY, CS_N, MOSI}, 3'b100);
    sb.push_back('{6'd5, 16'hA5C3, 1'b0, t0 + T_STORE});
    n = 0;
    while (BUSY === 1'b1 && n < 2000) begin
      @(posedge CLK);
      #1;
      n++;
    end
    chk("busy_len", n, T_BUSY);
    chk("tx_cmd", pcap[31:24], 8'h03);
    chk("tx_addr", pcap[23:0], 24'h00000A);
    chk("single_we_count", we_cnt, 1);

    // erased word
    prom_word = 16'hFFFF;
    accept(6'd0);
    sb.push_back('{6'd0, 16'hFFFF, 1'b1, cyc + T_STORE});
    wait_idle("blank");
    chk("blank_we_count", we_cnt, 1);
    chk("blank_data_hold", DATA_OUT, 16'hFFFF);

    // requests during a transaction are dropped; ADDR changes ignored
    prom_word = 16'h0F0F;
    accept(6'd9);
    t0 = cyc;
    sb.push_back('{6'd9, 16'h0F0F, 1'b0, t0 + T_STORE});
    run_to(t0 + 2);
    ADDR = 6'd7;
    run_to(t0 + 9);
    EXECUTE = 1'b1;
    @(posedge CLK);
    #1 EXECUTE = 1'b0;
    run_to(t0 + 199);
    EXECUTE = 1'b1;
    @(posedge CLK);
    #1 EXECUTE = 1'b0;
    wait_idle("ignored");
    repeat (5) @(negedge CLK);
    chk("ignored_we_count", we_cnt, 2);
    chk("ignored_not_queued", BUSY, 1'b0);
    chk("ignored_waddr", WADDR, 6'd9);

    // base address wrap on the second instance
    @(negedge CLK) w_exe = 1'b1;
    @(posedge CLK);
    #1 w_exe = 1'b0;
    n = 0;
    while (w_busy !== 1'b0 && n < 2000) begin
      @(posedge CLK);
      #1;
      n++;
    end
    chk("wrap_idle_bound", n < 2000, 1);
    chk("wrap_cmd", wcap[31:24], 8'h03);
    chk("wrap_addr", wcap[23:0], 24'h000000);

    // sequencer-style sweep over the whole parameter table
    prom_integ = 1'b1;
    min_gap    = 1000;
    base       = we_cnt;
    for (int a = 0; a < 34; a++) begin
      accept(6'(a));
      sb.push_back('{6'(a), 16'(a) ^ 16'h5A00, 1'b0, cyc + T_STORE});
      wait_idle("integ");
    end
    repeat (3) @(negedge CLK);
    chk("integ_we_count", we_cnt - base, 34);
    chk("integ_sb_drained", sb.size(), 0);
    chk("integ_cs_gap", min_gap >= 2 * N, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    n_err++;
    $display("FAIL global_timeout observed=running expected=finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/al_prom_reader.md
# al_prom_reader

Responder side of the parameter auto-load handshake. On each EXECUTE pulse from the auto-load sequencer it reads one 16-bit word from the serial parameter PROM at the requested word address via SPI mode 0, and writes that word into the parameter register bank. It holds BUSY for the whole transaction and returns to idle, ready for the next EXECUTE.

## Interface
- CLK_DIV, 4: CLK cycles per SCK half-period (N); legal range 2..15.
- CMD_READ, 8'h03: PROM read opcode.
- BASE_ADDR, 24'h000000: PROM byte address of parameter word 0.
- CLK  input  1  system clock; everything is on the rising edge.
- RST  input  1  reset, asynchronous, active-high.
- EXECUTE  input  1  one-cycle read request.
- ADDR  input  6  word address; sampled only when EXECUTE is accepted.
- BUSY  output  1  transaction in progress (registered).
- WE  output  1  one-cycle write strobe to the parameter bank.
- BLANK  output  1  one-cycle flag: word read was 16'hFFFF (erased PROM).
- WADDR  output  6  latched word address; valid while WE/BLANK.
- DATA_OUT  output  16  word read; valid while WE/BLANK, held until the next accept.
- CS_N  output  1  PROM chip select, active-low.
- SCK  output  1  SPI clock; idles low.
- MOSI  output  1  SPI data to PROM.
- MISO  input  1  SPI data from PROM.

## Operation
- Reset values: BUSY=0, WE=0, BLANK=0, WADDR=0, DATA_OUT=0, CS_N=1, SCK=0, MOSI=0.
- States:
  - Idle
    - EXECUTE && !BUSY → Shift.
    - Latch ADDR into WADDR.
    - Load a 32-bit shift register with {CMD_READ, BASE_ADDR + 2*ADDR}; the sum is 24-bit and wraps modulo 2^24.
  - Shift
    - 48 SCK bits: 8 command, 24 address, 16 data.
    - MSB first on MOSI; MOSI=0 during data bits.
    - MISO is shifted into a data register, MSB first.
    - After the falling edge of bit 47 → Store.
  - Store (1 cycle)
    - CS_N=1.
    - DATA_OUT is updated.
    - Data != 16'hFFFF: WE=1.
    - Data == 16'hFFFF: BLANK=1 and WE=0; the bank keeps its default.
    - → Deselect.
  - Deselect
    - CS_N held high for 2N-1 further cycles.
    - Then BUSY=0 → Idle.
- EXECUTE while BUSY is ignored: no queueing, no error.
- RST mid-transaction: all outputs return to reset values immediately. There is no partial write. The PROM sees CS_N rise, which terminates its read.
- An ADDR change after the accept has no effect; the sequencer increments ADDR while BUSY is high.

## Timing
- Edge 0 is the edge that samples EXECUTE=1. After it: BUSY=1, CS_N=0, MOSI=command bit 7.
- Bit i (0..47):
  - SCK rises at edge N+2N·i.
  - SCK falls at edge 2N(i+1).
  - MISO is sampled at the edge that raises SCK.
  - MOSI changes at the edge that lowers SCK.
- Store occurs at edge 96N: WE/BLANK high for exactly one cycle, CS_N=1 from this edge.
- BUSY falls at edge 98N, giving 98N cycles of BUSY. With N=4 this is 392 cycles.
- The earliest next accept is edge 98N+1.
- BUSY rises exactly one cycle after EXECUTE. A sequencer that checks !BUSY two cycles after issuing EXECUTE therefore always sees BUSY=1.

## Structure
- Shared package `al_pkg`:
  - state encoding (Idle, Shift, Store, Deselect)
  - constants MAX_ADDR=6'd33, CMD_READ default, BLANK_WORD=16'hFFFF.
- Sub-module `spi_tick_gen` (CLK, RST, EN, N):
  - Issues rise/fall one-cycle enables every N cycles.
  - Counter clears when EN=0.
- Top level contains the FSM, a 6-bit bit counter, the 32-bit TX shift register and the 16-bit RX shift register.

## Test plan
1. Reset check: assert RST mid-idle and mid-Shift (edge 100). Required: all outputs at reset values within the same cycle, no WE, next EXECUTE is accepted normally.
2. Single read: ADDR=5, PROM model returns 16'hA5C3. Required:
   - MOSI carries 0x03 then 0x00000A;
   - WE=1 at edge 384 (N=4) with WADDR=5, DATA_OUT=16'hA5C3;
   - BUSY high 392 cycles.
3. Blank word: ADDR=0, model returns 16'hFFFF. Required: BLANK=1 for one cycle, WE stays 0, DATA_OUT=16'hFFFF.
4. Ignored requests: EXECUTE pulsed at edges 10 and 200 during a transaction, with ADDR changed to 7 at edge 3. Required: exactly one WE, WADDR=original ADDR.
5. Base-address wrap: BASE_ADDR=24'hFFFFFE, ADDR=1. Required: transmitted address 24'h000000.
6. Integration with the auto-load sequencer, PROM model returning ADDR^16'h5A00 for ADDR 0..33. Required:
   - 34 WE strobes in order;
   - COMPLETED asserted;
   - no overlapping transactions (CS_N high ≥2N cycles between reads).
